vga_layer_scheduler: RTL and testbench

Pixel-source scheduler for the single-bit-per-channel VGA output. Sits between `hvsync_generator` (beam position, display-area flag) and the VGA_R/G/B pins. Each clock it arbitrates between a sprite layer, an edge-detector overlay layer and an internally generated background test pattern. A frame-locked mode state machine cycles the background pattern every N frames.

---
 rtl/vga_layer_scheduler.sv | 84 ++++++++
 tb/tb_vga_layer_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vga_layer_scheduler.sv
// vga_layer_scheduler: picks sprite, overlay or background for each pixel and steps the background pattern at frame boundaries.
// Define VGA_LAYER_SCHED_OVERLAY_EN to let the overlay (edge) layer join arbitration.
module vga_layer_scheduler #(
    parameter int STRIPE_DIV      = 9,
    parameter int FRAMES_PER_MODE = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       inDisplayArea,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       sprite_req,
    input  logic [2:0] sprite_rgb,
    input  logic       edge_req,
    input  logic [2:0] edge_rgb,
    input  logic       mode_next,
    output logic       VGA_R,
    output logic       VGA_G,
    output logic       VGA_B,
    output logic [1:0] grant,
    output logic [1:0] cur_mode
);
    typedef enum logic [1:0] {BLACK, STRIPE, CHECKER, WHITE} mode_t;

    localparam logic [3:0] STRIPE_LAST = 4'(STRIPE_DIV - 1);
    localparam logic [7:0] FRAME_LAST  = 8'(FRAMES_PER_MODE - 1);

    mode_t      mode_q, mode_d;
    logic [7:0] frame_q, frame_d;
    logic [3:0] stripe_q, stripe_d;
    logic       pend_q, pend_d;
    logic [2:0] rgb_q, rgb_d, bg;
    logic [1:0] grant_q, grant_d;
    logic       boundary, advance, ov_req;

`ifdef VGA_LAYER_SCHED_OVERLAY_EN
    assign ov_req = edge_req;
`else
    logic unused_edge;
    assign ov_req      = 1'b0;
    assign unused_edge = edge_req;
`endif

    assign boundary = (CounterX == 10'd0) && (CounterY == 9'd0);

    // Background uses next-state mode and stripe count so pixel (0,0) already shows the new mode.
    always_comb begin
        advance  = boundary && (pend_q || frame_q == FRAME_LAST);
        mode_d   = advance ? mode_t'(mode_q + 2'd1) : mode_q;
        frame_d  = !boundary ? frame_q : advance ? 8'd0 : frame_q + 8'd1;
        pend_d   = boundary ? mode_next : (pend_q | mode_next);
        stripe_d = (CounterX == 10'd0) ? 4'd0 :
                   !inDisplayArea ? stripe_q :
                   (stripe_q == STRIPE_LAST) ? 4'd0 : stripe_q + 4'd1;
        bg       = (mode_d == BLACK)   ? 3'b000 :
                   (mode_d == WHITE)   ? 3'b111 :
                   (mode_d == CHECKER) ? {3{CounterX[3] ^ CounterY[3]}} :
                   {3{stripe_d == STRIPE_LAST}};
        rgb_d    = !inDisplayArea ? 3'b000 : sprite_req ? sprite_rgb : ov_req ? edge_rgb : bg;
        grant_d  = !inDisplayArea ? 2'd3 : sprite_req ? 2'd1 : ov_req ? 2'd2 : 2'd0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q   <= BLACK;
            frame_q  <= 8'd0;
            stripe_q <= 4'd0;
            pend_q   <= 1'b0;
            rgb_q    <= 3'b000;
            grant_q  <= 2'd3;
        end else begin
            mode_q   <= mode_d;
            frame_q  <= frame_d;
            stripe_q <= stripe_d;
            pend_q   <= pend_d;
            rgb_q    <= rgb_d;
            grant_q  <= grant_d;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign grant                 = grant_q;
    assign cur_mode              = mode_q;
endmodule

// File: tb/tb_vga_layer_scheduler.sv
// tb_vga_layer_scheduler: random and directed stimulus on a miniature raster, checked against a behavioural model.
module tb_vga_layer_scheduler;
    localparam int DIV = 4;
    localparam int FPM = 2;
    localparam int W   = 20;
    localparam int H   = 4;
`ifdef VGA_LAYER_SCHED_OVERLAY_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic       CLK = 1'b0, RST_N = 1'b0, disp = 1'b0;
    logic [9:0] cx = '0;
    logic [8:0] cy = '0;
    logic       sreq = 1'b0, ereq = 1'b0, mnext = 1'b0;
    logic [2:0] srgb = '0, ergb = '0;
    logic       VGA_R, VGA_G, VGA_B;
    logic [1:0] grant, cur_mode, mb;

    int checks = 0, errors = 0;
    int m_mode = 0, m_fc = 0, m_stripe = 0;
    bit m_pend = 1'b0;
    logic [2:0] e_rgb = '0;
    logic [1:0] e_grant = 2'd3;
    logic [1:0] seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    always #5 CLK = ~CLK;

    vga_layer_scheduler #(.STRIPE_DIV(DIV), .FRAMES_PER_MODE(FPM)) dut (
        .CLK(CLK), .RST_N(RST_N), .inDisplayArea(disp), .CounterX(cx), .CounterY(cy),
        .sprite_req(sreq), .sprite_rgb(srgb), .edge_req(ereq), .edge_rgb(ergb),
        .mode_next(mnext), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .grant(grant), .cur_mode(cur_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [2:0] bg;
        @(posedge CLK);
        if (!RST_N) begin
            m_mode = 0; m_fc = 0; m_pend = 1'b0; m_stripe = 0;
            e_rgb = 3'b000; e_grant = 2'd3;
        end else begin
            if (cx == 0 && cy == 0) begin
                if (m_pend || m_fc == FPM - 1) begin
                    m_mode = (m_mode + 1) % 4;
                    m_fc = 0;
                end else m_fc++;
                m_pend = mnext;
            end else m_pend = m_pend | mnext;
            m_stripe = (cx == 0) ? 0 : disp ? (m_stripe + 1) % DIV : m_stripe;
            bg = (m_mode == 0) ? 3'b000 : (m_mode == 3) ? 3'b111 :
                 (m_mode == 2) ? ((cx[3] ^ cy[3]) ? 3'b111 : 3'b000) :
                 ((m_stripe == DIV - 1) ? 3'b111 : 3'b000);
            if (!disp) begin e_rgb = 3'b000; e_grant = 2'd3; end
            else if (sreq) begin e_rgb = srgb; e_grant = 2'd1; end
            else if (OV && ereq) begin e_rgb = ergb; e_grant = 2'd2; end
            else begin e_rgb = bg; e_grant = 2'd0; end
        end
        #1;
        chk("rgb", {VGA_R, VGA_G, VGA_B}, e_rgb);
        chk("grant", grant, e_grant);
        chk("cur_mode", cur_mode, m_mode[1:0]);
    endtask

    task automatic run_frame(input bit quiet, input int p0, input int p1, input int p2,
                             input bit stripe_chk, output logic [1:0] mode_at_bnd);
        mode_at_bnd = 2'bxx;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int idx;
                idx   = y * W + x;
                cx    = 10'(x);
                cy    = 9'(y);
                disp  = (x < W - 4) && (y < H - 1);
                sreq  = quiet ? 1'b0 : 1'($urandom_range(0, 1));
                ereq  = quiet ? 1'b0 : 1'($urandom_range(0, 1));
                srgb  = 3'($urandom);
                ergb  = 3'($urandom);
                mnext = (idx == p0) || (idx == p1) || (idx == p2);
                tick();
                if (idx == 0) mode_at_bnd = cur_mode;
                if (stripe_chk && disp)
                    chk("stripe", {VGA_R, VGA_G, VGA_B}, (x % DIV == DIV - 1) ? 3'b111 : 3'b000);
            end
        end
        mnext = 1'b0;
    endtask

    initial begin
        cx = 10'd7; cy = 9'd2; disp = 1'b1; sreq = 1'b1; srgb = 3'b101; ereq = 1'b1; ergb = 3'b011;
        RST_N = 1'b0;
        repeat (3) tick();
        chk("reset_rgb", {VGA_R, VGA_G, VGA_B}, 3'b000);
        chk("reset_grant", grant, 2'd3);
        chk("reset_mode", cur_mode, 2'd0);
        RST_N = 1'b1; cx = 10'd8;
        tick();
        chk("post_reset_rgb", {VGA_R, VGA_G, VGA_B}, 3'b101);
        chk("post_reset_grant", grant, 2'd1);

        cx = 10'd9; srgb = 3'b100; ergb = 3'b010;
        tick();
        chk("prio_sprite_rgb", {VGA_R, VGA_G, VGA_B}, 3'b100);
        chk("prio_sprite_grant", grant, 2'd1);
        sreq = 1'b0; cx = 10'd10;
        tick();
        chk("prio_edge_rgb", {VGA_R, VGA_G, VGA_B}, OV ? 3'b010 : 3'b000);
        chk("prio_edge_grant", grant, OV ? 2'd2 : 2'd0);

        disp = 1'b0; sreq = 1'b1; cx = 10'd11;
        tick();
        chk("blank_rgb", {VGA_R, VGA_G, VGA_B}, 3'b000);
        chk("blank_grant", grant, 2'd3);

        RST_N = 1'b0; cx = 10'd5;
        tick();
        RST_N = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_frame(1'b0, -1, -1, -1, 1'b0, mb);
            chk("mode_seq", mb, seq[k]);
        end

        run_frame(1'b0, 10, -1, -1, 1'b0, mb);
        chk("b9_mode", mb, 2'd0);
        run_frame(1'b0, 10, 30, 50, 1'b0, mb);
        chk("coincide_single_adv", mb, 2'd1);
        run_frame(1'b0, -1, -1, -1, 1'b0, mb);
        chk("mode_next_adv", mb, 2'd2);
        run_frame(1'b0, -1, -1, -1, 1'b0, mb);
        chk("fc_cleared_hold", mb, 2'd2);
        run_frame(1'b0, 0, -1, -1, 1'b0, mb);
        chk("natural_after_clear", mb, 2'd3);
        run_frame(1'b0, -1, -1, -1, 1'b0, mb);
        chk("bnd_pulse_deferred", mb, 2'd0);

        cx = 10'd6; cy = 9'd1; disp = 1'b1; mnext = 1'b1;
        tick();
        mnext = 1'b0; RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        run_frame(1'b1, -1, -1, -1, 1'b0, mb);
        chk("reset_discard_b1", mb, 2'd0);
        run_frame(1'b1, -1, -1, -1, 1'b1, mb);
        chk("stripe_frame_mode", mb, 2'd1);

        repeat (6) run_frame(1'b0, int'($urandom_range(0, W * H - 1)), -1, -1, 1'b0, mb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
